reg_bank_arbiter: RTL and testbench

Shared register bank with a round-robin write arbiter. N_REQ requesters compete for a single write port into a bank of 2**ADDR_W registers of DATA_W bits, each register being a plain clocked flop with the common reset. One asynchronous read port serves the datapath. The block sits between the control agents, which request writes, and the datapath, which consumes the register contents.

---
 rtl/reg_arb_pkg.sv | 23 ++
 rtl/reg_arb_rr_pick.sv | 37 +++
 rtl/reg_bank_arbiter.sv | 159 +++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types and defaults for the register-bank arbiter.
//   state_t  : arbiter state (IDLE, GRANT, HOLD)
//   ptr_w()  : width of a requester index for a given requester count
//   DEF_*    : default parameter values used by the arbiter modules
package reg_arb_pkg;

    localparam int unsigned DEF_N_REQ    = 4;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_ADDR_W   = 3;
    localparam int unsigned DEF_MAX_HOLD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // At least one bit so a single-entry index is still a legal vector.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_arb_rr_pick.sv
// reg_arb_rr_pick: combinational rotating-priority selector.
//   i_req [N_REQ]  request vector
//   i_ptr [PTR_W]  index of the last winner; search starts at i_ptr+1
//   o_gnt [N_REQ]  one-hot-or-zero grant
//   o_idx [PTR_W]  encoded winner index (0 when nothing is requested)
module reg_arb_rr_pick
    import reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    localparam int unsigned PTR_W = ptr_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0] o_idx
);

    int unsigned w_cand;
    logic        w_found;

    // Scan ptr+1, ptr+2, ... wrapping; the first asserted request wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_cand = (32'(i_ptr) + k) % N_REQ;
            if (!w_found && i_req[PTR_W'(w_cand)]) begin
                w_found                = 1'b1;
                o_gnt[PTR_W'(w_cand)]  = 1'b1;
                o_idx                  = PTR_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: register bank with a round-robin arbitrated write port
// and a combinational read port.
//   clk, reset (async, active-high)
//   req[N_REQ], wr_addr[N_REQ*ADDR_W], wr_data[N_REQ*DATA_W] : write requests
//   lock[N_REQ] : grant-hold request (only with REG_ARB_LOCK_EN)
//   gnt[N_REQ]  : same-cycle one-hot-or-zero grant
//   rd_addr, rd_data : asynchronous read of the registered bank
//   busy        : any request pending
// Build option: define REG_ARB_LOCK_EN to enable locked multi-cycle grants
// (up to MAX_HOLD consecutive grants to one requester).
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = DEF_N_REQ,
    parameter int unsigned DATA_W   = DEF_DATA_W,
`ifdef REG_ARB_LOCK_EN
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
`endif
    parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*ADDR_W-1:0]    wr_addr,
    input  logic [N_REQ*DATA_W-1:0]    wr_data,
`ifdef REG_ARB_LOCK_EN
    input  logic [N_REQ-1:0]           lock,
`endif
    output logic [N_REQ-1:0]           gnt,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned PTR_W = ptr_w(N_REQ);

    logic [DATA_W-1:0] r_bank [DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    state_t            r_state;

    logic [PTR_W-1:0]  w_ptr_nxt;
    state_t            w_state_nxt;
    logic [N_REQ-1:0]  w_rr_gnt;
    logic [PTR_W-1:0]  w_rr_idx;
    logic [N_REQ-1:0]  w_gnt;
    logic [PTR_W-1:0]  w_win;
    logic              w_grant;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;

`ifdef REG_ARB_LOCK_EN
    localparam int unsigned HCNT_W = ptr_w(MAX_HOLD + 1);
    logic [HCNT_W-1:0] r_hold_cnt;
    logic [HCNT_W-1:0] w_hold_cnt_nxt;
    logic              w_in_hold;
`endif

    reg_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx)
    );

    // Grant selection and next-state logic.
    always_comb begin
        w_gnt       = w_rr_gnt;
        w_win       = w_rr_idx;
        w_ptr_nxt   = r_ptr;
        w_state_nxt = r_state;
`ifdef REG_ARB_LOCK_EN
        w_hold_cnt_nxt = r_hold_cnt;
        // While holding, ptr still names the locked owner.
        w_in_hold = (r_state == HOLD) && req[r_ptr];
        if (w_in_hold) begin
            w_gnt        = '0;
            w_gnt[r_ptr] = 1'b1;
            w_win        = r_ptr;
        end
`endif
        if (reset) begin
            w_gnt = '0;
        end
        w_grant = |w_gnt;
        if (w_grant) begin
            w_ptr_nxt = w_win;
        end

`ifdef REG_ARB_LOCK_EN
        if (w_in_hold) begin
            if (!lock[w_win] || (r_hold_cnt + HCNT_W'(1)) == HCNT_W'(MAX_HOLD)) begin
                w_state_nxt    = GRANT;
                w_hold_cnt_nxt = '0;
            end else begin
                w_state_nxt    = HOLD;
                w_hold_cnt_nxt = r_hold_cnt + HCNT_W'(1);
            end
        end else if (w_grant && lock[w_win] && (MAX_HOLD > 1)) begin
            // The entering grant counts as the first of the hold.
            w_state_nxt    = HOLD;
            w_hold_cnt_nxt = HCNT_W'(1);
        end else begin
            w_state_nxt    = w_grant ? GRANT : IDLE;
            w_hold_cnt_nxt = '0;
        end
`else
        case (r_state)
            IDLE, GRANT: w_state_nxt = w_grant ? GRANT : IDLE;
            default:     w_state_nxt = IDLE;
        endcase
`endif
    end

    // Write demux: route the winner's address and data to the bank.
    always_comb begin
        w_wr_addr = '0;
        w_wr_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_wr_addr = wr_addr[i*ADDR_W +: ADDR_W];
                w_wr_data = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr      <= PTR_W'(N_REQ - 1);
            r_state    <= IDLE;
`ifdef REG_ARB_LOCK_EN
            r_hold_cnt <= '0;
`endif
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_state    <= w_state_nxt;
`ifdef REG_ARB_LOCK_EN
            r_hold_cnt <= w_hold_cnt_nxt;
`endif
        end
    end

    // Register bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_grant) begin
            r_bank[w_wr_addr] <= w_wr_data;
        end
    end

    assign gnt     = w_gnt;
    assign rd_data = r_bank[rd_addr];
    assign busy    = |req;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed self-checking bench for reg_bank_arbiter
// with default parameters (4 requesters, 8-bit data, 8 entries).
// Lock-mode scenario is compiled in only with REG_ARB_LOCK_EN.
module tb_reg_bank_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  lock;
    logic [3:0]  gnt;
    logic [2:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;

    int n_vec;
    int n_err;

    reg_bank_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`ifdef REG_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_src(input int i, input logic [2:0] a, input logic [7:0] d);
        wr_addr[i*3 +: 3] = a;
        wr_data[i*8 +: 8] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        req     = '0;
        lock    = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if (gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_gnt got %b want 0000", gnt);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            n_vec++;
            if (rd_data !== 8'h00) begin
                n_err++;
                $display("FAIL reset_rd[%0d] got %h want 00", a, rd_data);
            end
        end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        set_src(2, 3'd5, 8'hA5);
        req     = 4'b0100;
        rd_addr = 3'd5;
        #1;
        n_vec++;
        if (gnt !== 4'b0100) begin
            n_err++;
            $display("FAIL single_gnt got %b want 0100", gnt);
        end
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_busy got %b want 1", busy);
        end
        n_vec++;
        if (rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL single_old got %h want 00", rd_data);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (rd_data !== 8'hA5) begin
            n_err++;
            $display("FAIL single_new got %h want a5", rd_data);
        end
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        exp_g[0] = 4'b0001;
        exp_g[1] = 4'b0010;
        exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000;
        exp_g[4] = 4'b0001;
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 3'(i), 8'(8'hC0 + i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_vec++;
            if (gnt !== exp_g[k]) begin
                n_err++;
                $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, exp_g[k]);
            end
            @(negedge clk);
        end
        req = '0;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 3'(i);
            #1;
            n_vec++;
            if (rd_data !== 8'(8'hC0 + i)) begin
                n_err++;
                $display("FAIL rr_rd[%0d] got %h want %h", i, rd_data, 8'(8'hC0 + i));
            end
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        set_src(1, 3'd6, 8'h66);
        set_src(3, 3'd7, 8'h77);
        req     = 4'b0010;
        rd_addr = 3'd6;
        #1;
        n_vec++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL rstpend_gnt got %b want 0010", gnt);
        end
        #1;
        reset = 1'b1;
        #1;
        n_vec++;
        if (gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL rstpend_forced got %b want 0000", gnt);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b1010;
        #1;
        n_vec++;
        if (rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL rstpend_rd got %h want 00", rd_data);
        end
        n_vec++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL rstpend_first got %b want 0010", gnt);
        end
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_same_addr();
        do_reset();
        set_src(1, 3'd2, 8'h11);
        set_src(3, 3'd2, 8'h33);
        req     = 4'b1010;
        rd_addr = 3'd2;
        #1;
        n_vec++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL same_gnt1 got %b want 0010", gnt);
        end
        @(negedge clk);
        req = 4'b1000;
        #1;
        n_vec++;
        if (rd_data !== 8'h11) begin
            n_err++;
            $display("FAIL same_mid got %h want 11", rd_data);
        end
        n_vec++;
        if (gnt !== 4'b1000) begin
            n_err++;
            $display("FAIL same_gnt2 got %b want 1000", gnt);
        end
        @(negedge clk);
        req = '0;
        #1;
        n_vec++;
        if (rd_data !== 8'h33) begin
            n_err++;
            $display("FAIL same_final got %h want 33", rd_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g [5];
        exp_g[0] = 4'b0001;
        exp_g[1] = 4'b0001;
        exp_g[2] = 4'b0100;
        exp_g[3] = 4'b0001;
        exp_g[4] = 4'b0100;
        do_reset();
        set_src(0, 3'd1, 8'h01);
        set_src(2, 3'd3, 8'h03);
        req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) req = 4'b0101;
            #1;
            n_vec++;
            if (gnt !== exp_g[k]) begin
                n_err++;
                $display("FAIL b2b_gnt[%0d] got %b want %b", k, gnt, exp_g[k]);
            end
            @(negedge clk);
        end
        req = '0;
    endtask

`ifdef REG_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        set_src(0, 3'd0, 8'hAA);
        set_src(1, 3'd1, 8'hBB);
        req  = 4'b0011;
        lock = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++;
            if (gnt !== 4'b0001) begin
                n_err++;
                $display("FAIL lock_hold[%0d] got %b want 0001", k, gnt);
            end
            @(negedge clk);
        end
        #1;
        n_vec++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL lock_release got %b want 0010", gnt);
        end
        @(negedge clk);
        req  = '0;
        lock = '0;
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_reset_pending();
        test_same_addr();
        test_back_to_back();
`ifdef REG_ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
